// File: rtl/mc_ctrl_defs.sv
// mc_ctrl_defs: state, opcode and datapath-select encodings for the multi-cycle MIPS controller
package mc_ctrl_defs;
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_ALU_WB   = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_ADDI_EX  = 4'd9;
    localparam logic [3:0] S_ADDI_WB  = 4'd10;
    localparam logic [3:0] S_JUMP     = 4'd11;
    localparam logic [5:0] INSTR_OP_RTYPE = 6'h00;
    localparam logic [5:0] INSTR_OP_J     = 6'h02;
    localparam logic [5:0] INSTR_OP_BEQ   = 6'h04;
    localparam logic [5:0] INSTR_OP_ADDI  = 6'h08;
    localparam logic [5:0] INSTR_OP_LW    = 6'h23;
    localparam logic [5:0] INSTR_OP_SW    = 6'h2B;
    localparam logic [1:0] ALUOp_ADD   = 2'b00;
    localparam logic [1:0] ALUOp_SUB   = 2'b01;
    localparam logic [1:0] ALUOp_FUNCT = 2'b10;
    localparam logic [1:0] SRC_B_REG     = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SL2 = 2'b11;
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
    localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       imm_extend;
    } ctrl_t;
endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational map from state and opcodes to control vector and next state
module mc_ctrl_decode
    import mc_ctrl_defs::*;
(
    input  logic [3:0] state,
    input  logic [5:0] opcode,
    input  logic [5:0] op_q,
    output ctrl_t      ctrl,
    output logic [3:0] nxt
);
    always_comb begin
        ctrl = '0;
        nxt  = S_FETCH;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = 1'b1;
                ctrl.pc_write  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                nxt            = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRC_B_IMM_SL2;
                ctrl.imm_extend = 1'b1;
                case (opcode)
                    INSTR_OP_LW, INSTR_OP_SW: nxt = S_MEM_ADDR;
                    INSTR_OP_RTYPE:           nxt = S_EXEC;
                    INSTR_OP_BEQ:             nxt = S_BRANCH;
                    INSTR_OP_ADDI:            nxt = S_ADDI_EX;
                    INSTR_OP_J:               nxt = S_JUMP;
                    default:                  nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR, S_ADDI_EX: begin
                ctrl.alu_src_a  = 1'b1;
                ctrl.alu_src_b  = SRC_B_IMM;
                ctrl.imm_extend = 1'b1;
                nxt = (state == S_ADDI_EX) ? S_ADDI_WB : (op_q == INSTR_OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOp_FUNCT;
                nxt            = S_ALU_WB;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOp_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PC_SRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_SRC_JUMP;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                nxt           = S_MEM_WB;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RT;
                ctrl.mem_to_reg = MEM_TO_REG_MEM;
            end
            S_ALU_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = REG_DST_RD;
                ctrl.mem_to_reg = MEM_TO_REG_ALU;
            end
            S_ADDI_WB: ctrl.reg_write = 1'b1;
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS main controller; define MC_CTRL_MEM_WAIT_EN to stall memory states on mem_ready
module mc_ctrl
    import mc_ctrl_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       imm_extend,
    output logic       illegal_op,
    output logic [3:0] state
);
    ctrl_t      ctrl;
    logic [3:0] nxt;
    logic [5:0] op_q;
    logic       hold;
    mc_ctrl_decode u_decode (
        .state (state),
        .opcode(opcode),
        .op_q  (op_q),
        .ctrl  (ctrl),
        .nxt   (nxt)
    );
`ifdef MC_CTRL_MEM_WAIT_EN
    assign hold = !mem_ready && (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR);
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign hold = 1'b0;
`endif
    // PC and IR load only when the fetch actually completes; strobes are dead while in reset
    assign pc_write      = !rst && !hold && ctrl.pc_write;
    assign ir_write      = !rst && !hold && ctrl.ir_write;
    assign pc_write_cond = !rst && ctrl.pc_write_cond;
    assign mem_read      = !rst && ctrl.mem_read;
    assign mem_write     = !rst && ctrl.mem_write;
    assign reg_write     = !rst && ctrl.reg_write;
    assign i_or_d        = ctrl.i_or_d;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign imm_extend    = ctrl.imm_extend;
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_FETCH;
            op_q       <= '0;
            illegal_op <= 1'b0;
        end else begin
            if (!hold) state <= nxt;
            if (state == S_DECODE) op_q <= opcode;
            if (state == S_DECODE && nxt == S_FETCH) illegal_op <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: randomized scoreboard bench for mc_ctrl against an instruction-sequence reference model
module tb_mc_ctrl;
    import mc_ctrl_defs::*;
`ifdef MC_CTRL_MEM_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic       alu_src_a, imm_extend, illegal_op;
    logic [3:0] state;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .imm_extend(imm_extend), .illegal_op(illegal_op),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       ill;
        ctrl_t      o;
    } obs_t;

    obs_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    logic ill_exp = 1'b0;

    // Control outputs written straight from the per-state table of the datapath contract
    function automatic ctrl_t spec_out(input logic [3:0] s, input logic rdy, input logic r);
        ctrl_t c;
        c = '0;
        if (s == S_FETCH) begin
            c.mem_read = 1'b1; c.ir_write = !WAIT_EN || rdy; c.pc_write = !WAIT_EN || rdy;
            c.alu_src_b = 2'b01;
        end
        if (s == S_DECODE) begin c.alu_src_b = 2'b11; c.imm_extend = 1'b1; end
        if (s == S_MEM_ADDR || s == S_ADDI_EX) begin
            c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.imm_extend = 1'b1;
        end
        if (s == S_EXEC) begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
        if (s == S_BRANCH) begin
            c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
        end
        if (s == S_JUMP) begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
        if (s == S_MEM_RD) begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
        if (s == S_MEM_WR) begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
        if (s == S_MEM_WB) begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
        if (s == S_ALU_WB) begin c.reg_write = 1'b1; c.reg_dst = 2'b01; end
        if (s == S_ADDI_WB) c.reg_write = 1'b1;
        if (r) begin
            c.pc_write = 1'b0; c.pc_write_cond = 1'b0; c.mem_read = 1'b0;
            c.mem_write = 1'b0; c.ir_write = 1'b0; c.reg_write = 1'b0;
        end
        return c;
    endfunction

    function automatic bit known_op(input logic [5:0] op);
        return op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    endfunction

    // One instruction: rst_at is the cycle index that sees reset (-1 = none), low_wr forces wait cycles in MEM_WR
    task automatic run_instr(input logic [5:0] op, input int rst_at, input int low_wr);
        logic [3:0] seq[$];
        int   i;
        int   n;
        int   low_left;
        logic rdy;
        logic r;
        seq = '{S_FETCH, S_DECODE};
        if (op == 6'h23) seq = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB};
        if (op == 6'h2B) seq = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR};
        if (op == 6'h00) seq = '{S_FETCH, S_DECODE, S_EXEC, S_ALU_WB};
        if (op == 6'h08) seq = '{S_FETCH, S_DECODE, S_ADDI_EX, S_ADDI_WB};
        if (op == 6'h04) seq = '{S_FETCH, S_DECODE, S_BRANCH};
        if (op == 6'h02) seq = '{S_FETCH, S_DECODE, S_JUMP};
        i = 0;
        n = 0;
        low_left = low_wr;
        while (i < seq.size()) begin
            @(posedge clk);
            #1;
            rdy = ($urandom_range(0, 3) != 0);
            if (seq[i] == S_MEM_WR && low_left > 0) begin
                rdy = 1'b0;
                low_left--;
            end
            r = (n == rst_at);
            rst = r;
            mem_ready = rdy;
            opcode = (seq[i] == S_DECODE) ? op : 6'($urandom);
            exp_q.push_back({seq[i], ill_exp, spec_out(seq[i], rdy, r)});
            if (r) begin
                ill_exp = 1'b0;
                return;
            end
            if (seq[i] == S_DECODE && !known_op(op)) ill_exp = 1'b1;
            if (!(WAIT_EN && !rdy && (seq[i] == S_FETCH || seq[i] == S_MEM_RD || seq[i] == S_MEM_WR))) i++;
            n++;
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t g;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {state, illegal_op, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, imm_extend};
            tests += 3;
            if (g.st !== e.st) begin
                fails++;
                $display("FAIL state cycle %0d: got %0d expected %0d", cyc, g.st, e.st);
            end
            if (g.ill !== e.ill) begin
                fails++;
                $display("FAIL illegal_op cycle %0d: got %b expected %b", cyc, g.ill, e.ill);
            end
            if (g.o !== e.o) begin
                fails++;
                $display("FAIL ctrl cycle %0d state %0d: got %05h expected %05h", cyc, e.st, g.o, e.o);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops[7];
        logic [5:0] op;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02, 6'h3F};
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back({S_FETCH, 1'b0, spec_out(S_FETCH, mem_ready, 1'b1)});
        run_instr(6'h23, -1, 0);
        run_instr(6'h00, -1, 0);
        run_instr(6'h08, -1, 0);
        run_instr(6'h04, -1, 0);
        run_instr(6'h02, -1, 0);
        run_instr(6'h3F, -1, 0);
        run_instr(6'h23, -1, 0);
        run_instr(6'h2B, -1, 3);
        run_instr(6'h23, 4, 0);
        run_instr(6'h23, -1, 0);
        for (int k = 0; k < 300; k++) begin
            op = ops[$urandom_range(0, 6)];
            if (op == 6'h3F) op = 6'($urandom);
            run_instr(op, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1,
                      int'($urandom_range(0, 2)));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
